// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share arbiter: datapath widths, opcode
// encodings and the arbiter FSM state type.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RES_W  = DATA_W + 1;
  localparam int unsigned OPC_W  = 3;

  localparam logic [OPC_W-1:0] OP_NOP = 3'b000;
  localparam logic [OPC_W-1:0] OP_ADD = 3'b001;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b010;
  localparam logic [OPC_W-1:0] OP_AND = 3'b011;
  localparam logic [OPC_W-1:0] OP_OR  = 3'b100;
  localparam logic [OPC_W-1:0] OP_XOR = 3'b101;
  localparam logic [OPC_W-1:0] OP_NOT = 3'b110;
  localparam logic [OPC_W-1:0] OP_INV = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage : alu_pkg

// File: rtl/alu_share_arbiter_alu_core.sv
// Combinational ALU datapath.
//   opcode        : operation select (alu_pkg encodings)
//   op1, op2      : operands
//   result[32:0]  : result, bit 32 is carry (ADD) or borrow (SUB)
//   overflow      : bit 32 for ADD/SUB, 0 for every other opcode
module alu_core
  import alu_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic [RES_W-1:0]  result,
  output logic              overflow
);

  // Logic ops are zero-extended; NOP and the invalid opcode yield zero.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        result   = {1'b0, op1} + {1'b0, op2};
        overflow = result[DATA_W];
      end
      OP_SUB: begin
        result   = {1'b0, op1} - {1'b0, op2};
        overflow = result[DATA_W];
      end
      OP_AND:  result = {1'b0, op1 & op2};
      OP_OR:   result = {1'b0, op1 | op2};
      OP_XOR:  result = {1'b0, op1 ^ op2};
      OP_NOT:  result = {1'b0, ~op1};
      default: result = '0;
    endcase
  end

endmodule : alu_core

// File: rtl/alu_share_arbiter.sv
// Two-requester front end sharing one ALU core.
//   clk, rst_n                 : clock, async active-low reset
//   reqN_valid/ready/opcode/op1/op2 : request channel of requester N
//   rspN_valid/ready/result/overflow : response channel of requester N
//   busy                       : FSM not idle
//   owner                      : requester currently holding the ALU
// PRIO_FIXED = 0 round-robins ties; 1 lets requester 0 win every tie.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OPC_W-1:0]  req0_opcode,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OPC_W-1:0]  req1_opcode,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [RES_W-1:0]  rsp0_result,
  output logic              rsp0_overflow,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [RES_W-1:0]  rsp1_result,
  output logic              rsp1_overflow,
  output logic              busy,
  output logic              owner
);

  state_t              state;
  logic                owner_q;
  logic                last_gnt;
  logic [OPC_W-1:0]    opc_q;
  logic [DATA_W-1:0]   op1_q;
  logic [DATA_W-1:0]   op2_q;
  logic [RES_W-1:0]    res_q;
  logic                ovf_q;

  logic                win_c;
  logic                accept_c;
  logic                rsp_ready_c;
  logic [RES_W-1:0]    alu_res_c;
  logic                alu_ovf_c;

  // Winner selection: a lone requester wins; a tie goes by policy.
  always_comb begin
    win_c = 1'b0;
    if (req0_valid && req1_valid) begin
      win_c = PRIO_FIXED ? 1'b0 : ~last_gnt;
    end else if (req1_valid) begin
      win_c = 1'b1;
    end
  end

  // Ready is held low while reset is asserted even though state reads IDLE.
  assign accept_c    = rst_n && (state == ST_IDLE) && (req0_valid || req1_valid);
  assign req0_ready  = accept_c && !win_c;
  assign req1_ready  = accept_c &&  win_c;
  assign rsp_ready_c = owner_q ? rsp1_ready : rsp0_ready;

  alu_core u_alu_core (
    .opcode   (opc_q),
    .op1      (op1_q),
    .op2      (op2_q),
    .result   (alu_res_c),
    .overflow (alu_ovf_c)
  );

  // FSM, operand capture and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner_q  <= 1'b0;
      last_gnt <= 1'b1;
      opc_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req0_valid || req1_valid) begin
            owner_q <= win_c;
            opc_q   <= win_c ? req1_opcode : req0_opcode;
            op1_q   <= win_c ? req1_op1    : req0_op1;
            op2_q   <= win_c ? req1_op2    : req0_op2;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q <= alu_res_c;
          ovf_q <= alu_ovf_c;
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_c) begin
            last_gnt <= owner_q;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = (state != ST_IDLE);
  assign owner         = owner_q;
  assign rsp0_valid    = (state == ST_RESP) && !owner_q;
  assign rsp1_valid    = (state == ST_RESP) &&  owner_q;
  assign rsp0_result   = res_q;
  assign rsp1_result   = res_q;
  assign rsp0_overflow = ovf_q;
  assign rsp1_overflow = ovf_q;

endmodule : alu_share_arbiter
